// File: rtl/rob_pkg.sv
// Shared types and width constants for the reorder-buffer retire block.
// The entry struct widths follow the default register/ROB configuration below.
package rob_pkg;

    localparam int DEF_NUM_PHYS_REGS = 64;
    localparam int DEF_NUM_ARCH_REGS = 35;
    localparam int DEF_ROB_DEPTH     = 32;
    localparam int DEF_RETIRE_WIDTH  = 2;

    localparam int ENT_PHYS_W = $clog2(DEF_NUM_PHYS_REGS);
    localparam int ENT_ARCH_W = $clog2(DEF_NUM_ARCH_REGS);

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  mispredict;
        logic                  has_dest;
        logic [ENT_ARCH_W-1:0] arch;
        logic [ENT_PHYS_W-1:0] phys;
        logic [ENT_PHYS_W-1:0] old_phys;
    } rob_entry_t;

endpackage

// File: rtl/rrat_mw.sv
// Retirement register alias table with RETIRE_WIDTH ordered write ports.
// Higher-numbered ports (younger retirements) win on same-address writes.
module rrat_mw
    import rob_pkg::*;
#(
    parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
    parameter int NUM_PHYS_REGS = DEF_NUM_PHYS_REGS,
    parameter int RETIRE_WIDTH  = DEF_RETIRE_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [RETIRE_WIDTH-1:0]                        we_i,
    input  logic [RETIRE_WIDTH*$clog2(NUM_ARCH_REGS)-1:0]  waddr_i,
    input  logic [RETIRE_WIDTH*$clog2(NUM_PHYS_REGS)-1:0]  wdata_i,
    output logic [NUM_ARCH_REGS*$clog2(NUM_PHYS_REGS)-1:0] map_o
);

    localparam int ARCH_W = $clog2(NUM_ARCH_REGS);
    localparam int PHYS_W = $clog2(NUM_PHYS_REGS);

    logic [PHYS_W-1:0] map_q [NUM_ARCH_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_q[i] <= PHYS_W'(i);
            end
        end else begin
            for (int w = 0; w < RETIRE_WIDTH; w++) begin
                if (we_i[w] && (int'(waddr_i[w*ARCH_W +: ARCH_W]) < NUM_ARCH_REGS)) begin
                    map_q[waddr_i[w*ARCH_W +: ARCH_W]] <= wdata_i[w*PHYS_W +: PHYS_W];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_ARCH_REGS; g++) begin : g_map
        assign map_o[g*PHYS_W +: PHYS_W] = map_q[g];
    end

endmodule

// File: rtl/rob_retire.sv
// Reorder buffer with in-order multi-wide retirement, mispredict flush and RRAT.
// Define ROB_RETIRE_PERF_EN to build the retired-instruction counter.
module rob_retire
    import rob_pkg::*;
#(
    parameter int NUM_PHYS_REGS = DEF_NUM_PHYS_REGS,
    parameter int NUM_ARCH_REGS = DEF_NUM_ARCH_REGS,
    parameter int ROB_DEPTH     = DEF_ROB_DEPTH,
    parameter int RETIRE_WIDTH  = DEF_RETIRE_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           disp_valid,
    output logic                                           disp_ready,
    input  logic                                           disp_has_dest,
    input  logic [$clog2(NUM_ARCH_REGS)-1:0]               disp_arch,
    input  logic [$clog2(NUM_PHYS_REGS)-1:0]               disp_phys,
    input  logic [$clog2(NUM_PHYS_REGS)-1:0]               disp_old_phys,
    output logic [$clog2(ROB_DEPTH)-1:0]                   disp_tag,
    input  logic                                           cmpl_valid,
    input  logic [$clog2(ROB_DEPTH)-1:0]                   cmpl_tag,
    input  logic                                           cmpl_mispredict,
    output logic [RETIRE_WIDTH-1:0]                        ret_valid,
    output logic [RETIRE_WIDTH*$clog2(NUM_PHYS_REGS)-1:0]  ret_free_phys,
    output logic                                           flush,
    output logic [NUM_ARCH_REGS*$clog2(NUM_PHYS_REGS)-1:0] rrat_map,
    output logic [31:0]                                    perf_retired
);

    localparam int ARCH_W = $clog2(NUM_ARCH_REGS);
    localparam int PHYS_W = $clog2(NUM_PHYS_REGS);
    localparam int PTR_W  = $clog2(ROB_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    rob_entry_t                     rob_q [ROB_DEPTH];
    logic [PTR_W-1:0]               head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]               count_q, count_d, k;
    logic                           flush_q, mis_hit, disp_fire;
    logic [RETIRE_WIDTH-1:0]        ret_valid_q, ret_valid_d, rrat_we;
    logic [RETIRE_WIDTH*PHYS_W-1:0] ret_free_q, ret_free_d, rrat_wdata;
    logic [RETIRE_WIDTH*ARCH_W-1:0] rrat_waddr;
    logic [ROB_DEPTH-1:0]           ret_mask;

    // A retire in this cycle cannot free a slot for this cycle's dispatch.
    assign disp_ready = (count_q < CNT_W'(ROB_DEPTH)) && !flush_q;
    assign disp_fire  = disp_valid && disp_ready;
    assign disp_tag   = tail_q;

    // Walk from head; stop at the first not-ready entry or just after a mispredict.
    always_comb begin
        logic             stop;
        logic [PTR_W-1:0] idx;
        rob_entry_t       ent;
        stop        = 1'b0;
        idx         = '0;
        ent         = '0;
        k           = '0;
        mis_hit     = 1'b0;
        ret_mask    = '0;
        ret_valid_d = '0;
        ret_free_d  = '0;
        rrat_we     = '0;
        rrat_waddr  = '0;
        rrat_wdata  = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            idx = head_q + PTR_W'(i);
            ent = rob_q[idx];
            if (!stop && ent.valid && ent.done) begin
                k                                = k + CNT_W'(1);
                ret_mask[idx]                    = 1'b1;
                ret_valid_d[i]                   = ent.has_dest;
                ret_free_d[i*PHYS_W +: PHYS_W]   = ent.old_phys[PHYS_W-1:0];
                rrat_we[i]                       = ent.has_dest;
                rrat_waddr[i*ARCH_W +: ARCH_W]   = ent.arch[ARCH_W-1:0];
                rrat_wdata[i*PHYS_W +: PHYS_W]   = ent.phys[PHYS_W-1:0];
                if (ent.mispredict) begin
                    mis_hit = 1'b1;
                    stop    = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        head_d  = head_q + k[PTR_W-1:0];
        tail_d  = tail_q + PTR_W'(disp_fire);
        count_d = count_q + CNT_W'(disp_fire) - k;
        if (mis_hit) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            flush_q     <= 1'b0;
            ret_valid_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob_q[i] <= '0;
            end
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            flush_q     <= mis_hit;
            ret_valid_q <= ret_valid_d;
            if (mis_hit) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    rob_q[i].valid      <= 1'b0;
                    rob_q[i].done       <= 1'b0;
                    rob_q[i].mispredict <= 1'b0;
                end
            end else begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    if (ret_mask[i]) begin
                        rob_q[i].valid <= 1'b0;
                    end
                end
                if (cmpl_valid && rob_q[cmpl_tag].valid) begin
                    rob_q[cmpl_tag].done       <= 1'b1;
                    rob_q[cmpl_tag].mispredict <= cmpl_mispredict;
                end
                if (disp_fire) begin
                    rob_q[tail_q] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                                       has_dest: disp_has_dest, arch: disp_arch,
                                       phys: disp_phys, old_phys: disp_old_phys};
                end
            end
        end
    end

    // Freed register ids are only meaningful alongside ret_valid.
    always_ff @(posedge clk) begin
        ret_free_q <= ret_free_d;
    end

    assign ret_valid     = ret_valid_q;
    assign ret_free_phys = ret_free_q;
    assign flush         = flush_q;

    rrat_mw #(
        .NUM_ARCH_REGS (NUM_ARCH_REGS),
        .NUM_PHYS_REGS (NUM_PHYS_REGS),
        .RETIRE_WIDTH  (RETIRE_WIDTH)
    ) u_rrat (
        .clk     (clk),
        .rst     (reset),
        .we_i    (rrat_we),
        .waddr_i (rrat_waddr),
        .wdata_i (rrat_wdata),
        .map_o   (rrat_map)
    );

`ifdef ROB_RETIRE_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_q + 32'(k);
        end
    end

    assign perf_retired = perf_q;
`else
    assign perf_retired = '0;
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Randomized bench for rob_retire against a queue-based program-order model.
module tb_rob_retire;

    localparam int NP = 64, NA = 35, RD = 32, RW = 2;
    localparam int AW = 6, PW = 6, TW = 5;

    logic              clk, reset;
    logic              disp_valid, disp_ready, disp_has_dest;
    logic [AW-1:0]     disp_arch;
    logic [PW-1:0]     disp_phys, disp_old_phys;
    logic [TW-1:0]     disp_tag;
    logic              cmpl_valid, cmpl_mispredict;
    logic [TW-1:0]     cmpl_tag;
    logic [RW-1:0]     ret_valid;
    logic [RW*PW-1:0]  ret_free_phys;
    logic              flush;
    logic [NA*PW-1:0]  rrat_map;
    logic [31:0]       perf_retired;

    rob_retire #(
        .NUM_PHYS_REGS (NP),
        .NUM_ARCH_REGS (NA),
        .ROB_DEPTH     (RD),
        .RETIRE_WIDTH  (RW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .disp_valid      (disp_valid),
        .disp_ready      (disp_ready),
        .disp_has_dest   (disp_has_dest),
        .disp_arch       (disp_arch),
        .disp_phys       (disp_phys),
        .disp_old_phys   (disp_old_phys),
        .disp_tag        (disp_tag),
        .cmpl_valid      (cmpl_valid),
        .cmpl_tag        (cmpl_tag),
        .cmpl_mispredict (cmpl_mispredict),
        .ret_valid       (ret_valid),
        .ret_free_phys   (ret_free_phys),
        .flush           (flush),
        .rrat_map        (rrat_map),
        .perf_retired    (perf_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: program-order queue of tags plus per-tag attributes.
    int     q[$];
    bit     in_q[RD];
    bit     m_done[RD], m_mis[RD], m_hd[RD];
    int     m_arch[RD], m_phys[RD], m_old[RD];
    int     m_tail;
    int     m_rrat[NA];
    longint m_perf;
    bit     m_flush;

    function automatic logic [NA*PW-1:0] rrat_vec();
        logic [NA*PW-1:0] v;
        for (int i = 0; i < NA; i++) v[i*PW +: PW] = PW'(m_rrat[i]);
        return v;
    endfunction

    function automatic logic [31:0] exp_perf();
`ifdef ROB_RETIRE_PERF_EN
        return 32'(m_perf);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < RD; i++) begin
            in_q[i] = 0; m_done[i] = 0; m_mis[i] = 0;
        end
        for (int i = 0; i < NA; i++) m_rrat[i] = i;
        m_tail = 0; m_perf = 0; m_flush = 0;
    endtask

    task automatic set_idle();
        disp_valid = 0; disp_has_dest = 0; disp_arch = '0; disp_phys = '0; disp_old_phys = '0;
        cmpl_valid = 0; cmpl_tag = '0; cmpl_mispredict = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("rst_disp_ready", disp_ready, 1);
        check("rst_ret_valid", ret_valid, 0);
        check("rst_flush", flush, 0);
        check("rst_disp_tag", disp_tag, 0);
        check("rst_rrat_map", rrat_map, rrat_vec());
        check("rst_perf", perf_retired, 0);
    endtask

    task automatic cyc(input bit dv, input bit hd, input int arch, input int phys, input int old,
                       input bit cv, input int ct, input bit cm);
        bit            exp_ready, mis, cval;
        int            nret, t;
        logic [RW-1:0] erv;
        int            efp[RW];
        disp_valid = dv; disp_has_dest = hd; disp_arch = AW'(arch);
        disp_phys = PW'(phys); disp_old_phys = PW'(old);
        cmpl_valid = cv; cmpl_tag = TW'(ct); cmpl_mispredict = cm;
        exp_ready = (q.size() < RD) && !m_flush;
        check("disp_ready", disp_ready, exp_ready);
        check("disp_tag", disp_tag, m_tail);
        cval = cv && in_q[ct];
        nret = 0; mis = 0; erv = '0;
        for (int i = 0; i < RW; i++) efp[i] = 0;
        for (int i = 0; i < RW && i < q.size(); i++) begin
            t = q[i];
            if (!m_done[t]) break;
            nret++;
            if (m_hd[t]) begin
                erv[i] = 1'b1;
                efp[i] = m_old[t];
                m_rrat[m_arch[t]] = m_phys[t];
            end
            if (m_mis[t]) begin
                mis = 1;
                break;
            end
        end
        for (int i = 0; i < nret; i++) in_q[q.pop_front()] = 0;
        if (mis) begin
            foreach (q[i]) in_q[q[i]] = 0;
            q.delete();
            m_tail = 0;
        end else begin
            if (cval) begin
                m_done[ct] = 1; m_mis[ct] = cm;
            end
            if (dv && exp_ready) begin
                q.push_back(m_tail);
                in_q[m_tail] = 1; m_done[m_tail] = 0; m_mis[m_tail] = 0;
                m_hd[m_tail] = hd; m_arch[m_tail] = arch; m_phys[m_tail] = phys; m_old[m_tail] = old;
                m_tail = (m_tail + 1) % RD;
            end
        end
        m_perf += nret;
        m_flush = mis;
        @(posedge clk);
        #1;
        check("ret_valid", ret_valid, erv);
        for (int i = 0; i < RW; i++)
            if (erv[i]) check("ret_free_phys", ret_free_phys[i*PW +: PW], efp[i]);
        check("flush", flush, mis);
        check("rrat_map", rrat_map, rrat_vec());
        check("perf_retired", perf_retired, exp_perf());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_cyc();
        int ct;
        ct = ((q.size() > 0) && ($urandom_range(9) < 8)) ? q[$urandom_range(q.size() - 1)]
                                                         : int'($urandom_range(RD - 1));
        cyc($urandom_range(9) < 6, $urandom_range(3) != 0, $urandom_range(NA - 1),
            $urandom_range(NP - 1), $urandom_range(NP - 1),
            $urandom_range(9) < 7, ct, $urandom_range(39) == 0);
    endtask

    initial begin
        set_idle();
        do_reset();
        check("rrat_map[5]_reset", rrat_map[5*PW +: PW], 5);

        // In-order retirement of out-of-order completions.
        cyc(1, 1, 5, 40, 5, 0, 0, 0);
        cyc(1, 1, 6, 41, 6, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 2, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        idle(3);
        check("rrat_map[5]", rrat_map[5*PW +: PW], 40);
        check("rrat_map[6]", rrat_map[6*PW +: PW], 41);

        // Fill from tail 3 so the tail wraps, then free one slot.
        for (int i = 0; i < RD; i++) cyc(1, 1, i % NA, 10 + i, i, 0, 0, 0);
        check("full_ready", disp_ready, 0);
        cyc(1, 1, 1, 1, 1, 1, 3, 0);
        cyc(1, 1, 1, 1, 1, 0, 0, 0);
        cyc(1, 1, 2, 2, 2, 0, 0, 0);
        for (int i = 0; i < RD; i++) cyc(0, 0, 0, 0, 0, 1, (4 + i) % RD, 0);
        idle(20);

        // Same architectural register written twice in one retire group.
        do_reset();
        cyc(1, 1, 3, 50, 3, 0, 0, 0);
        cyc(1, 1, 3, 51, 50, 0, 0, 0);
        cyc(1, 1, 3, 52, 51, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 2, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("rrat_map[3]_pair", rrat_map[3*PW +: PW], 51);
        idle(2);
        check("rrat_map[3]_last", rrat_map[3*PW +: PW], 52);

        // Mispredict in the middle of a group.
        do_reset();
        cyc(1, 1, 7, 60, 7, 0, 0, 0);
        cyc(1, 1, 8, 61, 8, 0, 0, 0);
        cyc(1, 1, 9, 62, 9, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 2, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 1);
        idle(3);
        check("mis_next_tag", disp_tag, 0);
        check("mis_rrat_map[9]", rrat_map[9*PW +: PW], 9);

        // Randomized traffic with a reset in the middle.
        do_reset();
        for (int i = 0; i < 1500; i++) rand_cyc();
        do_reset();
        for (int i = 0; i < 1500; i++) rand_cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
